// File: rtl/traffic_light_fsm_if.sv
// Button/sensor inputs and light outputs of the traffic light controller.
// The master side drives the buttons and reads the lights; the slave side is the FSM.
interface traffic_light_fsm_if #(
  parameter int CNT_W = 4
);
  logic             tick_1hz;
  logic             reset_db;
  logic             walk_request_db;
  logic             reprogram_db;
  logic             sensor;
  logic [1:0]       time_sel;
  logic [CNT_W-1:0] time_value;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk_light;
  logic             walk_pending;
  logic [2:0]       state_out;

  modport master (
    output tick_1hz, reset_db, walk_request_db, reprogram_db, sensor, time_sel, time_value,
    input  main_light, side_light, walk_light, walk_pending, state_out
  );
  modport slave (
    input  tick_1hz, reset_db, walk_request_db, reprogram_db, sensor, time_sel, time_value,
    output main_light, side_light, walk_light, walk_pending, state_out
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Timed main/side/walk light sequencer with run-time programmable intervals.
// Button edges restart or reprogram the cycle; walk requests are latched until served.
module traffic_light_fsm #(
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
  parameter int T_YEL_DEF  = 2,
  parameter int CNT_W      = 4
) (
  input logic                clk,
  input logic                sys_reset,
  traffic_light_fsm_if.slave bus
);
  typedef enum logic [2:0] {
    S_MG = 3'd0, S_MY = 3'd1, S_WALK = 3'd2, S_SG = 3'd3, S_SY = 3'd4
  } state_t;
  typedef logic [CNT_W:0] cnt_t;

  localparam logic [CNT_W-1:0] BASE_D = CNT_W'(T_BASE_DEF);
  localparam logic [CNT_W-1:0] EXT_D  = CNT_W'(T_EXT_DEF);
  localparam logic [CNT_W-1:0] YEL_D  = CNT_W'(T_YEL_DEF);
  localparam cnt_t ONE = cnt_t'(1);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  state_t           state, state_n;
  cnt_t             cnt, cnt_n;
  logic [CNT_W-1:0] base, ext, yel, base_n, ext_n, yel_n;
  logic             pend, pend_n;
  logic             armed, rs_q, wk_q, rp_q;
  logic             rs_edge, wk_edge, rp_edge;
  logic [2:0]       main_q, side_q;
  logic             walk_q;

  // armed masks the first cycle after reset so a level already high then is not an edge
  assign rs_edge = armed & bus.reset_db        & ~rs_q;
  assign wk_edge = armed & bus.walk_request_db & ~wk_q;
  assign rp_edge = armed & bus.reprogram_db    & ~rp_q;

  function automatic logic [CNT_W-1:0] pick(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] d);
    return (v == '0) ? d : v;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    base_n  = base;
    ext_n   = ext;
    yel_n   = yel;
    if (rp_edge) begin
      case (bus.time_sel)
        2'd0:    base_n = pick(bus.time_value, BASE_D);
        2'd1:    ext_n  = pick(bus.time_value, EXT_D);
        2'd2:    yel_n  = pick(bus.time_value, YEL_D);
        default: ;
      endcase
      state_n = S_MG;
      cnt_n   = cnt_t'(base_n) - ONE;
    end else if (rs_edge) begin
      state_n = S_MG;
      cnt_n   = cnt_t'(base) - ONE;
      pend_n  = 1'b0;
    end else begin
      if (bus.tick_1hz) begin
        if (cnt == '0) begin
          case (state)
            S_MG: begin state_n = S_MY; cnt_n = cnt_t'(yel) - ONE; end
            S_MY: begin
              if (pend) begin
                state_n = S_WALK;
                cnt_n   = cnt_t'(ext) - ONE;
                pend_n  = 1'b0;
              end else begin
                state_n = S_SG;
                cnt_n   = (bus.sensor ? cnt_t'(base) + cnt_t'(ext) : cnt_t'(base)) - ONE;
              end
            end
            S_WALK: begin
              state_n = S_SG;
              cnt_n   = (bus.sensor ? cnt_t'(base) + cnt_t'(ext) : cnt_t'(base)) - ONE;
            end
            S_SG:    begin state_n = S_SY; cnt_n = cnt_t'(yel) - ONE; end
            default: begin state_n = S_MG; cnt_n = cnt_t'(base) - ONE; end
          endcase
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      // a new request in the S_WALK entry cycle survives the clear
      if (wk_edge) pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_reset) begin
      state  <= S_MG;
      cnt    <= cnt_t'(BASE_D) - ONE;
      base   <= BASE_D;
      ext    <= EXT_D;
      yel    <= YEL_D;
      pend   <= 1'b0;
      armed  <= 1'b0;
      rs_q   <= 1'b0;
      wk_q   <= 1'b0;
      rp_q   <= 1'b0;
      main_q <= L_G;
      side_q <= L_R;
      walk_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      base   <= base_n;
      ext    <= ext_n;
      yel    <= yel_n;
      pend   <= pend_n;
      armed  <= 1'b1;
      rs_q   <= bus.reset_db;
      wk_q   <= bus.walk_request_db;
      rp_q   <= bus.reprogram_db;
      walk_q <= (state_n == S_WALK);
      case (state_n)
        S_MG:    begin main_q <= L_G; side_q <= L_R; end
        S_MY:    begin main_q <= L_Y; side_q <= L_R; end
        S_SG:    begin main_q <= L_R; side_q <= L_G; end
        S_SY:    begin main_q <= L_R; side_q <= L_Y; end
        default: begin main_q <= L_R; side_q <= L_R; end
      endcase
    end
  end

  assign bus.main_light   = main_q;
  assign bus.side_light   = side_q;
  assign bus.walk_light   = walk_q;
  assign bus.walk_pending = pend;
  assign bus.state_out    = state;
endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: timed cycle, sensor extension, walk,
// reprogramming, soft reset and synchronous reset.
module tb_traffic_light_fsm;
  logic clk = 1'b0;
  logic sys_reset;
  int   checks = 0;
  int   failures = 0;

  traffic_light_fsm_if #(.CNT_W(4)) bus ();

  traffic_light_fsm #(.T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2), .CNT_W(4)) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    bus.tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic press_rp(input logic [1:0] sel, input logic [3:0] val);
    bus.time_sel = sel;
    bus.time_value = val;
    bus.reprogram_db = 1'b1;
    cycle();
    bus.reprogram_db = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset = 1'b0;
    bus.tick_1hz = 0; bus.reset_db = 0; bus.walk_request_db = 0; bus.reprogram_db = 0;
    bus.sensor = 0; bus.time_sel = 2'd3; bus.time_value = 4'd0;
    cycle(); cycle();
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_out); end
    checks++; if (bus.main_light !== 3'b001) begin failures++; $display("FAIL reset_main got=%b exp=001", bus.main_light); end
    checks++; if (bus.side_light !== 3'b100) begin failures++; $display("FAIL reset_side got=%b exp=100", bus.side_light); end
    checks++; if (bus.walk_light !== 1'b0) begin failures++; $display("FAIL reset_walk got=%b exp=0", bus.walk_light); end
    checks++; if (bus.walk_pending !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", bus.walk_pending); end
    sys_reset = 1'b1;
    cycle();
  endtask

  task automatic test_basic_cycle();
    logic [2:0] exp_s [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd3,
                               3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};
    logic [2:0] exp_m [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] exp_sd [16] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
                                3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
    for (int i = 0; i < 16; i++) begin
      tick1();
      checks++; if (bus.state_out !== exp_s[i]) begin failures++; $display("FAIL basic_state tick=%0d got=%0d exp=%0d", i+1, bus.state_out, exp_s[i]); end
      checks++; if (bus.main_light !== exp_m[i]) begin failures++; $display("FAIL basic_main tick=%0d got=%b exp=%b", i+1, bus.main_light, exp_m[i]); end
      checks++; if (bus.side_light !== exp_sd[i]) begin failures++; $display("FAIL basic_side tick=%0d got=%b exp=%b", i+1, bus.side_light, exp_sd[i]); end
    end
  endtask

  task automatic test_sensor();
    ticks(7);
    bus.sensor = 1'b1;
    tick1();
    bus.sensor = 1'b0;
    checks++; if (bus.state_out !== 3'd3) begin failures++; $display("FAIL sensor_entry got=%0d exp=3", bus.state_out); end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) bus.sensor = 1'b1;
      if (i == 5) bus.sensor = 1'b0;
      tick1();
      checks++; if (bus.state_out !== 3'd3) begin failures++; $display("FAIL sensor_hold tick=%0d got=%0d exp=3", i+1, bus.state_out); end
    end
    tick1();
    checks++; if (bus.state_out !== 3'd4) begin failures++; $display("FAIL sensor_exit got=%0d exp=4", bus.state_out); end
    ticks(2);
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL sensor_wrap got=%0d exp=0", bus.state_out); end
  endtask

  task automatic test_walk();
    cycle();
    bus.walk_request_db = 1'b1; cycle();
    checks++; if (bus.walk_pending !== 1'b1) begin failures++; $display("FAIL walk_latch got=%b exp=1", bus.walk_pending); end
    bus.walk_request_db = 1'b0; cycle();
    bus.walk_request_db = 1'b1; cycle();
    bus.walk_request_db = 1'b0; cycle();
    ticks(6);
    checks++; if (bus.state_out !== 3'd1 || bus.walk_pending !== 1'b1) begin failures++; $display("FAIL walk_my got=%0d/%b exp=1/1", bus.state_out, bus.walk_pending); end
    ticks(2);
    checks++; if (bus.state_out !== 3'd2) begin failures++; $display("FAIL walk_state got=%0d exp=2", bus.state_out); end
    checks++; if (bus.walk_light !== 1'b1) begin failures++; $display("FAIL walk_lamp got=%b exp=1", bus.walk_light); end
    checks++; if (bus.main_light !== 3'b100 || bus.side_light !== 3'b100) begin failures++; $display("FAIL walk_allred got=%b/%b exp=100/100", bus.main_light, bus.side_light); end
    checks++; if (bus.walk_pending !== 1'b0) begin failures++; $display("FAIL walk_clear got=%b exp=0", bus.walk_pending); end
    ticks(2);
    checks++; if (bus.state_out !== 3'd2) begin failures++; $display("FAIL walk_hold got=%0d exp=2", bus.state_out); end
    tick1();
    checks++; if (bus.state_out !== 3'd3 || bus.walk_light !== 1'b0) begin failures++; $display("FAIL walk_exit got=%0d/%b exp=3/0", bus.state_out, bus.walk_light); end
  endtask

  task automatic test_reprogram();
    ticks(2);
    press_rp(2'd2, 4'd5);
    checks++; if (bus.state_out !== 3'd0 || bus.main_light !== 3'b001) begin failures++; $display("FAIL rp_restart got=%0d/%b exp=0/001", bus.state_out, bus.main_light); end
    cycle();
    ticks(5);
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL rp_base got=%0d exp=0", bus.state_out); end
    tick1();
    ticks(4);
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL rp_yel_hold got=%0d exp=1", bus.state_out); end
    tick1();
    checks++; if (bus.state_out !== 3'd3) begin failures++; $display("FAIL rp_yel_exit got=%0d exp=3", bus.state_out); end
    press_rp(2'd0, 4'd3);
    cycle();
    ticks(2);
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL rp_base3_hold got=%0d exp=0", bus.state_out); end
    tick1();
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL rp_base3_exit got=%0d exp=1", bus.state_out); end
    press_rp(2'd0, 4'd0);
    cycle();
    ticks(5);
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL rp_default_hold got=%0d exp=0", bus.state_out); end
    tick1();
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL rp_default_exit got=%0d exp=1", bus.state_out); end
    press_rp(2'd3, 4'd1);
    cycle();
    ticks(6);
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL rp_none got=%0d exp=1", bus.state_out); end
  endtask

  task automatic test_soft_reset();
    ticks(5);
    bus.walk_request_db = 1'b1; cycle();
    bus.walk_request_db = 1'b0;
    ticks(7);
    checks++; if (bus.state_out !== 3'd4 || bus.walk_pending !== 1'b1) begin failures++; $display("FAIL srst_pre got=%0d/%b exp=4/1", bus.state_out, bus.walk_pending); end
    bus.reset_db = 1'b1;
    bus.walk_request_db = 1'b1;
    cycle();
    bus.walk_request_db = 1'b0;
    checks++; if (bus.state_out !== 3'd0) begin failures++; $display("FAIL srst_state got=%0d exp=0", bus.state_out); end
    checks++; if (bus.walk_pending !== 1'b0) begin failures++; $display("FAIL srst_pend got=%b exp=0", bus.walk_pending); end
    ticks(10);
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL srst_held got=%0d exp=1", bus.state_out); end
    tick1();
    checks++; if (bus.state_out !== 3'd3) begin failures++; $display("FAIL srst_keep_yel got=%0d exp=3", bus.state_out); end
    bus.reset_db = 1'b0;
    cycle();
  endtask

  task automatic test_sys_reset_walk();
    bus.walk_request_db = 1'b1; cycle();
    bus.walk_request_db = 1'b0;
    ticks(6 + 5 + 6 + 5);
    checks++; if (bus.state_out !== 3'd2) begin failures++; $display("FAIL sr_pre got=%0d exp=2", bus.state_out); end
    bus.walk_request_db = 1'b1;
    sys_reset = 1'b0;
    cycle();
    sys_reset = 1'b1;
    checks++; if (bus.state_out !== 3'd0 || bus.main_light !== 3'b001 || bus.side_light !== 3'b100) begin failures++; $display("FAIL sr_out got=%0d/%b/%b exp=0/001/100", bus.state_out, bus.main_light, bus.side_light); end
    checks++; if (bus.walk_light !== 1'b0 || bus.walk_pending !== 1'b0) begin failures++; $display("FAIL sr_walk got=%b/%b exp=0/0", bus.walk_light, bus.walk_pending); end
    cycle(); cycle(); cycle();
    checks++; if (bus.walk_pending !== 1'b0) begin failures++; $display("FAIL sr_held_level got=%b exp=0", bus.walk_pending); end
    bus.walk_request_db = 1'b0;
    ticks(6);
    checks++; if (bus.state_out !== 3'd1) begin failures++; $display("FAIL sr_base got=%0d exp=1", bus.state_out); end
    ticks(2);
    checks++; if (bus.state_out !== 3'd3) begin failures++; $display("FAIL sr_yel_default got=%0d exp=3", bus.state_out); end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_sensor();
    test_walk();
    test_reprogram();
    test_soft_reset();
    test_sys_reset_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
